// File: rtl/alg_dac_cdc_pkg.sv
// Shared constants, read-FSM state type and gray-code helpers for the alg->dac CDC path.
package alg_dac_cdc_pkg;
  localparam int DATA_W_DEF    = 16;
  localparam int ADDR_W_DEF    = 4;
  localparam int PRIME_LVL_DEF = 8;
  localparam int CNT_W         = 16;

  typedef enum logic {FILL = 1'b0, RUN = 1'b1} rd_state_t;

  // Helpers operate on 32 bits; callers size-cast to their own pointer width.
  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] gray);
    logic [31:0] bin;
    bin = gray;
    for (int i = 1; i < 32; i++) bin = bin ^ (gray >> i);
    return bin;
  endfunction
endpackage

// File: rtl/cdc_gray_async_fifo.sv
// Dual-clock FIFO: register-array storage, gray pointers registered at the source,
// 2-flop synchronizers at the destination, full on the write side, fill/empty on the read side.
module cdc_gray_async_fifo
  import alg_dac_cdc_pkg::*;
#(
  parameter int W      = 32,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic            wr_clk,
  input  logic            wr_rst_n,
  input  logic            wr_en,
  input  logic [W-1:0]    wr_data,
  output logic            full,
  input  logic            rd_clk,
  input  logic            rd_rst_n,
  input  logic            rd_en,
  output logic [W-1:0]    rd_data,
  output logic [ADDR_W:0] fill,
  output logic            empty
);
  localparam int PW    = ADDR_W + 1;
  localparam int DEPTH = 1 << ADDR_W;

  logic [W-1:0]    mem [DEPTH];
  logic [ADDR_W:0] wr_bin, wr_gray, wr_bin_nxt, rd_sync1, rd_sync2;
  logic [ADDR_W:0] rd_bin, rd_gray, rd_bin_nxt, wr_sync1, wr_sync2, wr_sync_bin;
  logic            wr_push, rd_pop;

  // Write domain
  assign wr_push    = wr_en && !full;
  assign wr_bin_nxt = wr_bin + PW'(1);
  assign full       = (wr_gray == {~rd_sync2[ADDR_W -: 2], rd_sync2[ADDR_W-2:0]});

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      wr_bin  <= '0;
      wr_gray <= '0;
    end else if (wr_push) begin
      wr_bin  <= wr_bin_nxt;
      wr_gray <= PW'(bin2gray(32'(wr_bin_nxt)));
    end
  end

  // NOTE: storage has no reset; clearing the pointers is what discards its contents.
  always_ff @(posedge wr_clk) begin
    if (wr_push) mem[wr_bin[ADDR_W-1:0]] <= wr_data;
  end

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      rd_sync1 <= '0;
      rd_sync2 <= '0;
    end else begin
      rd_sync1 <= rd_gray;
      rd_sync2 <= rd_sync1;
    end
  end

  // Read domain: fill lags the true level, so a pop never hits a truly empty FIFO.
  assign wr_sync_bin = PW'(gray2bin(32'(wr_sync2)));
  assign fill        = wr_sync_bin - rd_bin;
  assign empty       = (fill == '0);
  assign rd_pop      = rd_en && !empty;
  assign rd_bin_nxt  = rd_bin + PW'(1);
  assign rd_data     = mem[rd_bin[ADDR_W-1:0]];

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      wr_sync1 <= '0;
      wr_sync2 <= '0;
    end else begin
      wr_sync1 <= wr_gray;
      wr_sync2 <= wr_sync1;
    end
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      rd_bin  <= '0;
      rd_gray <= '0;
    end else if (rd_pop) begin
      rd_bin  <= rd_bin_nxt;
      rd_gray <= PW'(bin2gray(32'(rd_bin_nxt)));
    end
  end
endmodule

// File: rtl/alg_to_dac_cdc_tx.sv
// Carries paired A/B samples from alg_clk to dac_clk through one async FIFO entry per pair;
// the read side primes before streaming and re-primes after an underflow.
module alg_to_dac_cdc_tx
  import alg_dac_cdc_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int PRIME_LVL = PRIME_LVL_DEF
) (
  input  logic              alg_clk,
  input  logic              alg_rst_n,
  input  logic              dac_clk,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [CNT_W-1:0]  overflow_cnt,
  input  logic              dac_req,
  output logic [DATA_W-1:0] dac_a,
  output logic [DATA_W-1:0] dac_b,
  output logic              dac_valid,
  output logic              primed,
  output logic [CNT_W-1:0]  underflow_cnt
);
  localparam int PW = ADDR_W + 1;
  localparam logic [ADDR_W:0] PRIME_FILL = PW'(PRIME_LVL);

  logic              dac_rst_n;
  logic [1:0]        dac_rst_sync;
  logic              ready_en, full, empty, pop;
  logic [ADDR_W:0]   fill;
  logic [2*DATA_W-1:0] rd_data;
  rd_state_t         state;

  // dac reset: asserts with alg_rst_n, releases two dac_clk edges later.
  always_ff @(posedge dac_clk or negedge alg_rst_n) begin
    if (!alg_rst_n) dac_rst_sync <= 2'b00;
    else            dac_rst_sync <= {dac_rst_sync[0], 1'b1};
  end
  assign dac_rst_n = dac_rst_sync[1];

  // Holds in_ready low while in reset even though the empty FIFO is not full.
  always_ff @(posedge alg_clk or negedge alg_rst_n) begin
    if (!alg_rst_n) ready_en <= 1'b0;
    else            ready_en <= 1'b1;
  end
  assign in_ready = ready_en && !full;

  always_ff @(posedge alg_clk or negedge alg_rst_n) begin
    if (!alg_rst_n) begin
      overflow_cnt <= '0;
    end else if (in_valid && !in_ready && overflow_cnt != '1) begin
      overflow_cnt <= overflow_cnt + CNT_W'(1);
    end
  end

  cdc_gray_async_fifo #(
    .W      (2*DATA_W),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .wr_clk   (alg_clk),
    .wr_rst_n (alg_rst_n),
    .wr_en    (in_valid && in_ready),
    .wr_data  ({in_a, in_b}),
    .full     (full),
    .rd_clk   (dac_clk),
    .rd_rst_n (dac_rst_n),
    .rd_en    (pop),
    .rd_data  (rd_data),
    .fill     (fill),
    .empty    (empty)
  );

  assign pop    = (state == RUN) && dac_req && !empty;
  assign primed = (state == RUN);

  always_ff @(posedge dac_clk or negedge dac_rst_n) begin
    if (!dac_rst_n) begin
      state         <= FILL;
      dac_a         <= '0;
      dac_b         <= '0;
      dac_valid     <= 1'b0;
      underflow_cnt <= '0;
    end else begin
      dac_valid <= 1'b0;
      unique case (state)
        FILL: if (fill >= PRIME_FILL) state <= RUN;
        RUN: begin
          if (dac_req && !empty) begin
            dac_a     <= rd_data[2*DATA_W-1:DATA_W];
            dac_b     <= rd_data[DATA_W-1:0];
            dac_valid <= 1'b1;
          end else if (dac_req) begin
            state <= FILL;
            if (underflow_cnt != '1) underflow_cnt <= underflow_cnt + CNT_W'(1);
          end
        end
        default: state <= FILL;
      endcase
    end
  end
endmodule

// File: tb/tb_alg_to_dac_cdc_tx.sv
// Self-checking bench: directed and randomized traffic against a queue-based pair model.
`timescale 1ns/1ps
module tb_alg_to_dac_cdc_tx;
  logic        alg_clk = 1'b0, dac_clk = 1'b0, alg_rst_n = 1'b0;
  logic [15:0] in_a = '0, in_b = '0;
  logic        in_valid = 1'b0, dac_req = 1'b0;
  logic        in_ready, dac_valid, primed;
  logic [15:0] overflow_cnt, underflow_cnt, dac_a, dac_b;

  real alg_half = 5.0;
  real dac_half = 4.0;

  int          compared = 0, mismatched = 0;
  int          out_cnt = 0, ovf_events = 0;
  logic [31:0] model_q[$];
  bit          done;

  alg_to_dac_cdc_tx dut (
    .alg_clk       (alg_clk),
    .alg_rst_n     (alg_rst_n),
    .dac_clk       (dac_clk),
    .in_a          (in_a),
    .in_b          (in_b),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .overflow_cnt  (overflow_cnt),
    .dac_req       (dac_req),
    .dac_a         (dac_a),
    .dac_b         (dac_b),
    .dac_valid     (dac_valid),
    .primed        (primed),
    .underflow_cnt (underflow_cnt)
  );

  initial forever #(alg_half) alg_clk = ~alg_clk;
  initial forever #(dac_half) dac_clk = ~dac_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] sat16(input int n);
    return (n > 65535) ? 16'hFFFF : 16'(n);
  endfunction

  // Input monitor: an accepted pair joins the model, a refused one is a drop.
  always @(negedge alg_clk) begin
    if (alg_rst_n && in_valid) begin
      if (in_ready) model_q.push_back({in_a, in_b});
      else          ovf_events++;
    end
  end

  // Output monitor: every dac_valid must carry the oldest outstanding accepted pair.
  always @(negedge dac_clk) begin
    if (dac_valid) begin
      out_cnt++;
      compared++;
      assert (model_q.size() > 0) else begin
        mismatched++;
        $error("FAIL dac_unexpected: observed pair 0x%0h, none outstanding", {dac_a, dac_b});
      end
      if (model_q.size() > 0) check("dac_pair", {dac_a, dac_b}, model_q.pop_front());
    end
  end

  task automatic drive_pair(input logic v, input logic [15:0] a, input logic [15:0] b);
    @(posedge alg_clk);
    #1;
    in_valid = v;
    in_a     = a;
    in_b     = b;
  endtask

  task automatic set_req(input logic v);
    @(posedge dac_clk);
    #1 dac_req = v;
  endtask

  task automatic wait_outs(input int target, input int budget, input string tag);
    int n = 0;
    while (out_cnt < target && n < budget) begin
      @(negedge dac_clk);
      n++;
    end
    check(tag, out_cnt, target);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_overflow"}, overflow_cnt, 0);
    check({tag, "_dac_a"}, dac_a, 0);
    check({tag, "_dac_b"}, dac_b, 0);
    check({tag, "_dac_valid"}, dac_valid, 0);
    check({tag, "_primed"}, primed, 0);
    check({tag, "_underflow"}, underflow_cnt, 0);
  endtask

  task automatic assert_reset();
    alg_rst_n = 1'b0;
    in_valid  = 1'b0;
    dac_req   = 1'b0;
    #1;
    model_q.delete();
    ovf_events = 0;
  endtask

  task automatic release_reset();
    @(posedge alg_clk);
    #1 alg_rst_n = 1'b1;
    repeat (4) @(posedge dac_clk);
    repeat (2) @(posedge alg_clk);
  endtask

  task automatic sweep(input real ah, input real dh, input int n, input string tag);
    alg_half = ah;
    dac_half = dh;
    repeat (4) @(posedge dac_clk);
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < n; i++)
          drive_pair($urandom_range(0, 99) < 70, 16'($urandom), 16'($urandom));
        drive_pair(1'b0, 16'h0, 16'h0);
        done = 1'b1;
      end
      begin
        while (!done) set_req($urandom_range(0, 99) < 60);
      end
    join
    // Drain what can go, then pad past the prime level so the residue flushes.
    set_req(1'b1);
    repeat (300) @(posedge dac_clk);
    set_req(1'b0);
    for (int i = 0; i < 8; i++) drive_pair(1'b1, 16'hE000 + 16'(i), 16'h1E00 + 16'(i));
    drive_pair(1'b0, 16'h0, 16'h0);
    repeat (20) @(posedge dac_clk);
    set_req(1'b1);
    for (int i = 0; i < 400 && model_q.size() > 0; i++) @(negedge dac_clk);
    check({tag, "_drained"}, model_q.size(), 0);
    check({tag, "_overflow"}, overflow_cnt, sat16(ovf_events));
    set_req(1'b0);
  endtask

  initial begin
    #20ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    // Reset values, then priming with dac_req held high from the start.
    repeat (3) @(posedge alg_clk);
    #1 check_reset_vals("reset");
    release_reset();
    check("ready_after_reset", in_ready, 1);
    set_req(1'b1);
    for (int i = 0; i < 8; i++) drive_pair(1'b1, 16'h0001 + 16'(i), 16'h8001 + 16'(i));
    drive_pair(1'b0, 16'h0, 16'h0);
    check("not_primed_yet", primed, 0);
    for (int i = 0; i < 100 && !primed; i++) @(negedge dac_clk);
    check("primed_rise", primed, 1);
    check("no_output_before_prime", out_cnt, 0);
    wait_outs(8, 100, "first_8_out");

    // Drain into underflow: one count, outputs hold, back to FILL.
    repeat (10) @(negedge dac_clk);
    check("uf_count", underflow_cnt, 1);
    check("uf_primed", primed, 0);
    check("uf_valid", dac_valid, 0);
    check("uf_hold", {dac_a, dac_b}, 32'h0008_8008);
    for (int i = 0; i < 4; i++) drive_pair(1'b1, 16'h0101 + 16'(i), 16'h0201 + 16'(i));
    drive_pair(1'b0, 16'h0, 16'h0);
    repeat (20) @(negedge dac_clk);
    check("refill_no_pop", out_cnt, 8);
    check("refill_not_primed", primed, 0);
    for (int i = 4; i < 8; i++) drive_pair(1'b1, 16'h0101 + 16'(i), 16'h0201 + 16'(i));
    drive_pair(1'b0, 16'h0, 16'h0);
    wait_outs(16, 200, "refill_out");
    repeat (10) @(negedge dac_clk);
    check("uf_count_2", underflow_cnt, 2);

    // Fill to full with no reads: 16 accepted, 4 dropped.
    set_req(1'b0);
    repeat (10) @(posedge alg_clk);
    for (int i = 0; i < 20; i++) begin
      drive_pair(1'b1, 16'h1001 + 16'(i), 16'h9001 + 16'(i));
      check($sformatf("in_ready_%0d", i), in_ready, (i < 16));
    end
    drive_pair(1'b0, 16'h0, 16'h0);
    @(negedge alg_clk);
    check("overflow_4", overflow_cnt, 4);
    set_req(1'b1);
    wait_outs(32, 300, "full_readout");
    repeat (10) @(negedge dac_clk);
    check("uf_count_3", underflow_cnt, 3);

    // Reset mid-stream with 5 entries left and dac_valid toggling.
    set_req(1'b0);
    for (int i = 0; i < 13; i++) drive_pair(1'b1, 16'h2000 + 16'(i), 16'h3000 + 16'(i));
    drive_pair(1'b0, 16'h0, 16'h0);
    repeat (20) @(posedge dac_clk);
    for (int i = 0; i < 16; i++) set_req(i % 2 == 0);
    #1 assert_reset();
    check_reset_vals("midreset");
    repeat (3) @(posedge alg_clk);
    release_reset();
    base = out_cnt;
    set_req(1'b1);
    for (int i = 0; i < 8; i++) drive_pair(1'b1, 16'hA000 + 16'(i), 16'hB000 + 16'(i));
    drive_pair(1'b0, 16'h0, 16'h0);
    wait_outs(base + 8, 200, "post_reset_out");
    repeat (10) @(negedge dac_clk);
    check("post_reset_uf", underflow_cnt, 1);
    set_req(1'b0);

    // Randomized clock-ratio sweeps, both directions.
    sweep(8.138, 2.0, 1500, "sweep_slow_wr");
    sweep(2.0, 8.138, 1500, "sweep_fast_wr");

    // Overflow saturation with the read side idle.
    alg_half = 5.0;
    dac_half = 4.0;
    @(posedge alg_clk);
    #1 assert_reset();
    repeat (3) @(posedge alg_clk);
    release_reset();
    dac_half = 250.0;
    drive_pair(1'b1, 16'h5555, 16'hAAAA);
    repeat (65556) @(posedge alg_clk);
    #1 in_valid = 1'b0;
    @(negedge alg_clk);
    check("ovf_sat_model", overflow_cnt, sat16(ovf_events));
    check("ovf_sat_ffff", overflow_cnt, 32'h0000_FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
